alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Command sequencer for the 4-bit-operand / 8-bit accumulator ALU (Function 0=add, 1=mul, 2=shl, 3=hold low nibble).
//  Buffers {clear, function, data} commands from a requester in a FIFO and issues them to the ALU one at a time.
//  Drives the ALU's Data/Function/clear inputs and captures ALUout into a result register with a valid/ready handshake.
//  Sits between the control front-end and the ALU instance; the ALU is external and clocked by the same Clock.
// PARAMETERS
//  FIFO_DEPTH  4  command FIFO entries; power of two, >= 2
// PORTS
//  Clock         in   1       system clock, rising edge
//  Reset_b       in   1       reset: asynchronous, active-high
//  cmd_valid     in   1       command present on cmd_data
//  cmd_ready     out  1       FIFO can accept; = !full
//  cmd_data      in   7       [6]=clear ALU, [5:4]=function, [3:0]=data operand
//  res_valid     out  1       res_data holds an unconsumed result
//  res_ready     in   1       consumer takes result this cycle
//  res_data      out  8       ALUout captured for the command
//  busy          out  1       state != IDLE or FIFO non-empty
//  fifo_count    out  log2(FIFO_DEPTH)+1  entries held
//  alu_data      out  4       to ALU Data
//  alu_function  out  2       to ALU Function
//  alu_clear     out  1       to ALU reset input (sync, high clears ALUout)
//  alu_out       in   8       from ALU ALUout
// BEHAVIOUR
//  Reset (async, immediate): FIFO empty, pointers 0, state IDLE, res_valid=0, res_data=0, alu_function=3, alu_data=0,
//   alu_clear=1; alu_clear drops at first edge after Reset_b deasserts, so ALUout=0 after that edge.
//  Reset mid-operation: in-flight command and buffered commands are discarded; no result produced.
//  FIFO: push when cmd_valid&&cmd_ready; pop only in IDLE; no bypass (push into empty FIFO issues next cycle).
//   Pointers wrap modulo FIFO_DEPTH; push ignored when full (cmd_ready=0); push+pop same cycle keeps count.
//  FSM, all outputs registered:
//   IDLE:    alu_function=3, alu_data=0, alu_clear=0. If FIFO non-empty and (!res_valid || res_ready): pop,
//            load alu_function/alu_data from entry (clear bit -> alu_clear=1, alu_function=3, alu_data=0) -> ISSUE.
//   ISSUE:   ALU sees command for one cycle; at edge ALU updates; outputs return to hold (3/0/0) -> CAPTURE.
//   CAPTURE: alu_out is the command result; at edge res_data<=alu_out, res_valid<=1 -> IDLE.
//  Latency: command accepted at edge E0 -> result visible after E3. Max throughput 1 command / 3 cycles.
//  Result slot: res_valid clears on res_ready unless a new result loads same edge (CAPTURE wins, res_valid stays 1).
//   Issue gating guarantees a pending result is never overwritten.
//  Accumulator semantics follow the ALU: operands use ALUout[3:0]; hold (Function 3) in IDLE/CAPTURE-exit zeroes
//   ALUout[7:4], so chained commands see only the low nibble. Arithmetic is the ALU's 8-bit truncated result.
// CONFIGURATION
//  SEQ_COUNT_EN defined: adds output cmd_done_count[7:0]; +1 on each CAPTURE edge; wraps 255->0; reset 0.
//  SEQ_COUNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING (bench includes a behavioural ALU model on the alu_* ports)
//  Reset asserted during ISSUE -> all outputs at reset values immediately, fifo_count=0; after release alu_clear high one cycle, no res_valid.
//  Push 0x40(clr), 0x05(add5), 0x03(add3), res_ready=1 -> res_data 0x00, 0x05, 0x08 in order, each 3 cycles after issue.
//  Push 0x40, 0x0C, 0x1F(mul F), 0x01(add1) -> 0x00, 0x0C, 0xB4, 0x05 (upper nibble dropped by hold).
//  Push 0x40, 0x03, 0x24(shl 4) -> 0x00, 0x03, 0x30.
//  FIFO_DEPTH=4, res_ready=0, push 6 commands back-to-back -> 1 issued, fifo_count=4, cmd_ready=0, 6th rejected;
//   then res_ready=1 -> 5 results drained in push order, no loss or duplication.
//  SEQ_COUNT_EN: 256 add commands -> cmd_done_count returns to 0x00; 257th -> 0x01.

Source files
------------

// File: rtl/alu_sequencer.sv
// Command sequencer for the 4-bit-operand / 8-bit accumulator ALU: FIFO-buffered {clear,function,data}
// commands issued one at a time, result captured behind a valid/ready slot. Optional SEQ_COUNT_EN adds cmd_done_count.
module alu_sequencer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          Clock,
  input  logic                          Reset_b,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [6:0]                    cmd_data,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [7:0]                    res_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [3:0]                    alu_data,
  output logic [1:0]                    alu_function,
  output logic                          alu_clear,
  input  logic [7:0]                    alu_out
`ifdef SEQ_COUNT_EN
  ,
  output logic [7:0]                    cmd_done_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic       clr;
    logic [1:0] fn;
    logic [3:0] data;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  cmd_t          mem [FIFO_DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  state_t        state;
  logic          push, pop;

  assign cmd_ready = (fifo_count != FULL);
  assign push      = cmd_valid && cmd_ready;
  // Issue only when the result slot is free (or being freed this edge), so a result is never overwritten.
  assign pop       = (state == IDLE) && (fifo_count != '0) && (!res_valid || res_ready);
  assign head      = mem[rd_ptr];
  assign busy      = (state != IDLE) || (fifo_count != '0);

  always_ff @(posedge Clock) begin
    if (push) mem[wr_ptr] <= cmd_t'(cmd_data);
  end

  always_ff @(posedge Clock or posedge Reset_b) begin
    if (Reset_b) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset_b) begin
    if (Reset_b) begin
      state        <= IDLE;
      alu_function <= 2'd3;
      alu_data     <= '0;
      alu_clear    <= 1'b1;
      res_valid    <= 1'b0;
      res_data     <= '0;
    end else begin
      // ALU inputs default to hold; only the issuing edge presents a command.
      alu_function <= 2'd3;
      alu_data     <= '0;
      alu_clear    <= 1'b0;
      if (res_ready) res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            if (head.clr) begin
              alu_clear <= 1'b1;
            end else begin
              alu_function <= head.fn;
              alu_data     <= head.data;
            end
            state <= ISSUE;
          end
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          res_data  <= alu_out;
          res_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SEQ_COUNT_EN
  always_ff @(posedge Clock or posedge Reset_b) begin
    if (Reset_b)               cmd_done_count <= '0;
    else if (state == CAPTURE) cmd_done_count <= cmd_done_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural ALU on the alu_* ports.
module tb_alu_sequencer;
  localparam int D = 4;

  logic       Clock = 1'b0;
  logic       Reset_b = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [6:0] cmd_data = '0;
  logic       res_ready = 1'b1;
  logic       cmd_ready, res_valid, busy;
  logic [7:0] res_data;
  logic [$clog2(D):0] fifo_count;
  logic [3:0] alu_data;
  logic [1:0] alu_function;
  logic       alu_clear;
  logic [7:0] alu_q;
`ifdef SEQ_COUNT_EN
  logic [7:0] cmd_done_count;
`endif

  int n_pass = 0;
  int n_chk  = 0;
  logic [7:0] exp_q[$];

  alu_sequencer #(.FIFO_DEPTH(D)) dut (
    .Clock(Clock), .Reset_b(Reset_b),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .fifo_count(fifo_count),
    .alu_data(alu_data), .alu_function(alu_function), .alu_clear(alu_clear),
    .alu_out(alu_q)
`ifdef SEQ_COUNT_EN
    , .cmd_done_count(cmd_done_count)
`endif
  );

  always #5 Clock = ~Clock;

  // External ALU: operands use the low nibble of the accumulator.
  always @(posedge Clock) begin
    if (alu_clear) alu_q <= 8'h00;
    else case (alu_function)
      2'd0: alu_q <= {4'h0, alu_q[3:0]} + {4'h0, alu_data};
      2'd1: alu_q <= {4'h0, alu_q[3:0]} * {4'h0, alu_data};
      2'd2: alu_q <= {4'h0, alu_q[3:0]} << alu_data;
      default: alu_q <= {4'h0, alu_q[3:0]};
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: a result is consumed at the next rising edge whenever valid&&ready at the falling edge.
  always @(negedge Clock) begin
    if (!Reset_b && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_result: got 0x%0h expected none", res_data);
      end else begin
        check("result", 32'(res_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // Inputs change 1 time unit after a rising edge; cmd_ready is stable until the next edge.
  task automatic send(input logic [6:0] c, input logic [7:0] e, input bit expect_res);
    int n = 0;
    while (!cmd_ready && n < 100) begin
      @(posedge Clock); #1; n++;
    end
    if (!cmd_ready) begin
      n_chk++;
      $display("FAIL send_timeout: cmd_ready 0 expected 1");
    end else begin
      cmd_valid = 1'b1;
      cmd_data  = c;
      if (expect_res) exp_q.push_back(e);
      @(posedge Clock); #1;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 400) begin
      @(posedge Clock); #1; n++;
    end
    if (exp_q.size() != 0 || busy) begin
      n_chk++;
      $display("FAIL %s_timeout: pending %0d expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    Reset_b = 1'b1;
    repeat (2) @(posedge Clock);
    #1 Reset_b = 1'b0;
    @(posedge Clock); #1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge Clock);
    #1;
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res_data", 32'(res_data), 0);
    check("rst_alu_function", 32'(alu_function), 3);
    check("rst_alu_data", 32'(alu_data), 0);
    check("rst_alu_clear", 32'(alu_clear), 1);
    check("rst_fifo_count", 32'(fifo_count), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_busy", 32'(busy), 0);
    Reset_b = 1'b0;
    @(posedge Clock); #1;
    check("rel_alu_clear", 32'(alu_clear), 0);
    check("rel_alu_out", 32'(alu_q), 0);

    // Reset during ISSUE discards in-flight and buffered commands
    send(7'h05, 8'h00, 0);
    send(7'h03, 8'h00, 0);
    check("issue_alu_data", 32'(alu_data), 5);
    check("issue_fifo_count", 32'(fifo_count), 1);
    #2 Reset_b = 1'b1;
    #1;
    check("midrst_fifo_count", 32'(fifo_count), 0);
    check("midrst_alu_clear", 32'(alu_clear), 1);
    check("midrst_alu_function", 32'(alu_function), 3);
    check("midrst_alu_data", 32'(alu_data), 0);
    check("midrst_busy", 32'(busy), 0);
    @(negedge Clock) Reset_b = 1'b0;
    @(posedge Clock); #1;
    check("midrst_rel_alu_clear", 32'(alu_clear), 0);
    repeat (8) @(posedge Clock);
    #1;
    check("midrst_no_result", 32'(res_valid), 0);
    check("midrst_idle", 32'(busy), 0);

    // clear, add5, add3 with 3-cycle latency on the first
    send(7'h40, 8'h00, 1);
    @(posedge Clock); #1;
    check("lat_e1_valid", 32'(res_valid), 0);
    check("lat_e1_clear", 32'(alu_clear), 1);
    @(posedge Clock); #1;
    check("lat_e2_valid", 32'(res_valid), 0);
    @(posedge Clock); #1;
    check("lat_e3_valid", 32'(res_valid), 1);
    send(7'h05, 8'h05, 1);
    send(7'h03, 8'h08, 1);
    drain("add");

    // clear, add C, mul F, add1 (upper nibble dropped by hold)
    send(7'h40, 8'h00, 1);
    send(7'h0C, 8'h0C, 1);
    send(7'h1F, 8'hB4, 1);
    send(7'h01, 8'h05, 1);
    drain("mul");

    // clear, add3, shl4
    send(7'h40, 8'h00, 1);
    send(7'h03, 8'h03, 1);
    send(7'h24, 8'h30, 1);
    drain("shl");

    // Back-pressure: fill the FIFO behind a held result
    res_ready = 1'b0;
    send(7'h40, 8'h00, 1);
    send(7'h01, 8'h01, 1);
    send(7'h02, 8'h03, 1);
    send(7'h13, 8'h09, 1);
    send(7'h21, 8'h12, 1);
    check("full_fifo_count", 32'(fifo_count), 4);
    check("full_cmd_ready", 32'(cmd_ready), 0);
    check("full_res_valid", 32'(res_valid), 1);
    cmd_valid = 1'b1;
    cmd_data  = 7'h05;
    repeat (2) @(posedge Clock);
    #1 cmd_valid = 1'b0;
    check("reject_fifo_count", 32'(fifo_count), 4);
    check("held_res_data", 32'(res_data), 0);
    res_ready = 1'b1;
    drain("fifo");
    check("fifo_empty", 32'(fifo_count), 0);

`ifdef SEQ_COUNT_EN
    do_reset();
    check("cnt_reset", 32'(cmd_done_count), 0);
    for (int i = 0; i < 256; i++) send(7'h00, 8'h00, 1);
    drain("cnt256");
    check("cnt_wrap", 32'(cmd_done_count), 0);
    send(7'h01, 8'h01, 1);
    drain("cnt257");
    check("cnt_257", 32'(cmd_done_count), 1);
`else
    do_reset();
    check("final_reset_idle", 32'(busy), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
